cpu_commit_stage: RTL

//  Consumer end of the EX->MEM commit bundle: accepts the bundle (branch/mem_write/mem_read, mem_to_reg/
//  reg_write, add_result, alu_result, zero, rb, reg_dest), resolves the branch and performs the data-memory

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cpu_dmem_timeout.sv | 53 +++++
 rtl/cpu_commit_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Purpose: shared types and default widths for the EX->MEM commit stage.
//   commit_t       : memory/branch controls carried by a commit bundle
//   writeback_t    : writeback controls carried by a commit bundle
//   commit_state_e : commit stage FSM states
package cpu_pkg;

  localparam int unsigned DEFAULT_VIRTUAL_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_REG_WIDTH          = 32;
  localparam int unsigned DEFAULT_NUM_REGS           = 32;
  localparam int unsigned DEFAULT_REG_IDX_WIDTH      = $clog2(DEFAULT_NUM_REGS);
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES     = 255;

  typedef struct packed {
    logic branch;
    logic mem_write;
    logic mem_read;
  } commit_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } writeback_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } commit_state_e;

endpackage

// File: rtl/cpu_dmem_timeout.sv
// Purpose: data-memory access watchdog. Cleared by load_i, advances while
// count_i is high, and flags expire_o during the TIMEOUT_CYCLES-th counted cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load_i     : clear the counter (start of an access)
//   count_i    : access in progress, advance the counter
//   expire_o   : registered flag, access has used its full cycle budget
// Only instantiated when CPU_DMEM_TIMEOUT_EN is defined.
module cpu_dmem_timeout
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Counter value for the next cycle; expire is precomputed from it so the
  // flag is a flop output during the last allowed access cycle.
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (load_i || count_i) begin
      expire_d = (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/cpu_commit_stage.sv
// Purpose: consumer end of the EX->MEM commit bundle. Resolves branches,
// performs the data-memory access over a req/ack port and emits a registered
// writeback bundle. Back-pressures execute (in_ready=0) during an access.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   in_valid / in_ready     : commit bundle handshake
//   c_*                     : commit bundle fields
//   branch_taken/_target    : 1-cycle branch redirect at the bundle's retire
//   dmem_req/we/addr/wdata  : data-memory request, held until dmem_ack
//   dmem_ack/rdata          : data-memory response
//   wb_valid/reg_write/reg_dest/data : registered writeback bundle
//   mem_fault               : 1-cycle pulse on access timeout
// Build option: CPU_DMEM_TIMEOUT_EN adds the access watchdog (cpu_dmem_timeout);
// without it an access waits for dmem_ack indefinitely and mem_fault is 0.
module cpu_commit_stage
  import cpu_pkg::*;
#(
  parameter int unsigned VIRTUAL_ADDR_WIDTH = DEFAULT_VIRTUAL_ADDR_WIDTH,
  parameter int unsigned REG_WIDTH          = DEFAULT_REG_WIDTH,
  parameter int unsigned NUM_REGS           = DEFAULT_NUM_REGS,
  parameter int unsigned TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES,
  localparam int unsigned REG_IDX_WIDTH     = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          c_branch,
  input  logic                          c_mem_write,
  input  logic                          c_mem_read,
  input  logic                          c_mem_to_reg,
  input  logic                          c_reg_write,
  input  logic [VIRTUAL_ADDR_WIDTH-1:0] c_add_result,
  input  logic [REG_WIDTH-1:0]          c_alu_result,
  input  logic                          c_zero,
  input  logic [REG_WIDTH-1:0]          c_rb,
  input  logic [REG_IDX_WIDTH-1:0]      c_reg_dest,
  output logic                          branch_taken,
  output logic [VIRTUAL_ADDR_WIDTH-1:0] branch_target,
  output logic                          dmem_req,
  output logic                          dmem_we,
  output logic [VIRTUAL_ADDR_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0]          dmem_wdata,
  input  logic                          dmem_ack,
  input  logic [REG_WIDTH-1:0]          dmem_rdata,
  output logic                          wb_valid,
  output logic                          wb_reg_write,
  output logic [REG_IDX_WIDTH-1:0]      wb_reg_dest,
  output logic [REG_WIDTH-1:0]          wb_data,
  output logic                          mem_fault
);

  commit_state_e                 state_q, state_d;
  logic                          in_ready_q, in_ready_d;
  commit_t                       cmt_q, cmt_d;
  writeback_t                    wbc_q, wbc_d;
  logic [VIRTUAL_ADDR_WIDTH-1:0] add_q, add_d;
  logic [REG_WIDTH-1:0]          alu_q, alu_d;
  logic                          zero_q, zero_d;
  logic [REG_IDX_WIDTH-1:0]      dest_q, dest_d;
  logic                          req_q, req_d, we_q, we_d;
  logic [VIRTUAL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]          wdata_q, wdata_d;
  logic                          wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d;
  logic [REG_IDX_WIDTH-1:0]      wb_dest_q, wb_dest_d;
  logic [REG_WIDTH-1:0]          wb_data_q, wb_data_d;
  logic                          br_q, br_d;
  logic [VIRTUAL_ADDR_WIDTH-1:0] target_q, target_d;
  logic                          fault_q, fault_d;

`ifdef CPU_DMEM_TIMEOUT_EN
  logic tmo_load;
  logic tmo_expire;

  assign tmo_load = (state_q == IDLE) && in_valid && (c_mem_read || c_mem_write);

  cpu_dmem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tmo_load),
    .count_i  (state_q == ACCESS),
    .expire_o (tmo_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cmt_d      = cmt_q;
    wbc_d      = wbc_q;
    add_d      = add_q;
    alu_d      = alu_q;
    zero_d     = zero_q;
    dest_d     = dest_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_rw_d    = 1'b0;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    br_d       = 1'b0;
    target_d   = target_q;
    fault_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cmt_d  = '{branch: c_branch, mem_write: c_mem_write, mem_read: c_mem_read};
          wbc_d  = '{mem_to_reg: c_mem_to_reg, reg_write: c_reg_write};
          add_d  = c_add_result;
          alu_d  = c_alu_result;
          zero_d = c_zero;
          dest_d = c_reg_dest;
          if (c_mem_read || c_mem_write) begin
            state_d = ACCESS;
            req_d   = 1'b1;
            we_d    = c_mem_write;
            addr_d  = VIRTUAL_ADDR_WIDTH'(c_alu_result);
            wdata_d = c_rb;
          end else begin
            // No memory op: retire straight from the bundle.
            wb_valid_d = 1'b1;
            wb_rw_d    = c_reg_write;
            wb_dest_d  = c_reg_dest;
            wb_data_d  = c_alu_result;
            br_d       = c_branch & c_zero;
            target_d   = c_add_result;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          wb_valid_d = 1'b1;
          wb_rw_d    = wbc_q.reg_write;
          wb_dest_d  = dest_q;
          // A read+write bundle is a store, so it never returns load data.
          wb_data_d  = (wbc_q.mem_to_reg && cmt_q.mem_read && !cmt_q.mem_write)
                       ? dmem_rdata : alu_q;
          br_d       = cmt_q.branch & zero_q;
          target_d   = add_q;
        end
`ifdef CPU_DMEM_TIMEOUT_EN
        else if (tmo_expire) begin
          // Drop the bundle: no writeback, no branch redirect.
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          fault_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      cmt_q      <= '0;
      wbc_q      <= '0;
      add_q      <= '0;
      alu_q      <= '0;
      zero_q     <= 1'b0;
      dest_q     <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      br_q       <= 1'b0;
      target_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      cmt_q      <= cmt_d;
      wbc_q      <= wbc_d;
      add_q      <= add_d;
      alu_q      <= alu_d;
      zero_q     <= zero_d;
      dest_q     <= dest_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      br_q       <= br_d;
      target_q   <= target_d;
      fault_q    <= fault_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_rw_q;
  assign wb_reg_dest   = wb_dest_q;
  assign wb_data       = wb_data_q;
  assign branch_taken  = br_q;
  assign branch_target = target_q;
  assign mem_fault     = fault_q;

endmodule
